// File: rtl/cle_label_compact_pkg.sv
// cle_pkg: shared sizes, state encoding and terminal address for the label compactor.
package cle_pkg;
  localparam int IMG_DIM = 32;
  localparam int ADDR_W = 10;
  localparam int LABEL_W = 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SCAN, S_RD, S_WR, S_DONE} state_t;
endpackage

// File: rtl/cle_label_compact_if.sv
// cle_label_compact_if: single-port label SRAM bus; master drives address/data/strobe.
interface cle_label_compact_if;
  import cle_pkg::*;
  logic [ADDR_W-1:0] sram_a;
  logic [LABEL_W-1:0] sram_d;
  logic sram_wen;
  logic [LABEL_W-1:0] sram_q;
  modport master (output sram_a, sram_d, sram_wen, input sram_q);
  modport slave (input sram_a, sram_d, sram_wen, output sram_q);
endinterface

// File: rtl/cle_label_compact_map.sv
// cle_label_map: label remap table with valid bits; combinational lookup, clocked set/clear.
module cle_label_map
  import cle_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic set,
  input  logic [LABEL_W-1:0] set_idx,
  input  logic [LABEL_W-1:0] set_val,
  input  logic [LABEL_W-1:0] idx,
  output logic [LABEL_W-1:0] val,
  output logic hit
);
  localparam int N = 1 << LABEL_W;
  logic [N-1:0] valid;
  logic [LABEL_W-1:0] map [N];
  always_ff @(posedge clk) begin
    if (reset || clr) valid <= '0;
    else if (set) valid[set_idx] <= 1'b1;
    if (set) map[set_idx] <= set_val;
  end
  // label 0 is never set, so background always maps to 0
  assign hit = valid[idx];
  assign val = hit ? map[idx] : '0;
endmodule

// File: rtl/cle_label_compact.sv
// cle_label_compact: renumbers SRAM labels to 1..N in raster order of first appearance, in place.
// Optional CLE_AREA_STAT_EN adds per-label pixel counters readable via area_idx/area_q.
module cle_label_compact
  import cle_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  cle_label_compact_if.master sram,
  output logic busy,
  output logic done,
  output logic [LABEL_W-1:0] comp_count
`ifdef CLE_AREA_STAT_EN
  ,
  input  logic [LABEL_W-1:0] area_idx,
  output logic [ADDR_W-1:0] area_q
`endif
);
  state_t state;
  logic [LABEL_W:0] next_label;
  logic pv, drain, hit, is_new;
  logic [LABEL_W-1:0] map_val;
  logic [LABEL_W:0] cnt_end;
  // pv marks that sram_q holds a scanned pixel; drain is the extra cycle for pixel 1023
  assign is_new = state == S_SCAN && pv && sram.sram_q != '0 && !hit;
  assign cnt_end = next_label + {{LABEL_W{1'b0}}, is_new} - (LABEL_W+1)'(1);
  assign sram.sram_d = state == S_WR ? map_val : '0;
  cle_label_map u_map (
    .clk(clk), .reset(reset), .clr(state == S_CLR), .set(is_new),
    .set_idx(sram.sram_q), .set_val(next_label[LABEL_W-1:0]),
    .idx(sram.sram_q), .val(map_val), .hit(hit)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      sram.sram_a <= '0;
      sram.sram_wen <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      comp_count <= '0;
      next_label <= (LABEL_W+1)'(1);
      pv <= 1'b0;
      drain <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          state <= S_CLR;
          busy <= 1'b1;
          done <= 1'b0;
        end
        S_CLR: begin
          state <= S_SCAN;
          sram.sram_a <= '0;
          busy <= 1'b1;
          next_label <= (LABEL_W+1)'(1);
          pv <= 1'b0;
          drain <= 1'b0;
        end
        S_SCAN: begin
          pv <= 1'b1;
          if (is_new) next_label <= next_label + (LABEL_W+1)'(1);
          if (drain) begin
            state <= S_RD;
            sram.sram_a <= '0;
            comp_count <= cnt_end[LABEL_W] ? '1 : cnt_end[LABEL_W-1:0];
          end else if (&sram.sram_a) drain <= 1'b1;
          else sram.sram_a <= sram.sram_a + ADDR_W'(1);
        end
        S_RD: begin
          state <= S_WR;
          sram.sram_wen <= 1'b0;
        end
        S_WR: begin
          sram.sram_wen <= 1'b1;
          if (&sram.sram_a) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            state <= S_RD;
            sram.sram_a <= sram.sram_a + ADDR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef CLE_AREA_STAT_EN
  logic [ADDR_W-1:0] area [1 << LABEL_W];
  logic [LABEL_W-1:0] area_sel;
  assign area_sel = is_new ? next_label[LABEL_W-1:0] : map_val;
  always_ff @(posedge clk) begin
    if (state == S_CLR) for (int i = 0; i < (1 << LABEL_W); i++) area[i] <= '0;
    else if (state == S_SCAN && pv && sram.sram_q != '0) area[area_sel] <= area[area_sel] + ADDR_W'(1);
  end
  assign area_q = area_idx == '0 ? '0 : area[area_idx];
`endif
endmodule
